// File: rtl/folded_maj.sv
// Threshold/majority detector that folds an N-bit vector W bits per cycle.
// Valid/ready handshake: a transfer happens on a rising edge where valid && ready are both 1.
module folded_maj #(
    parameter int N     = 29,
    parameter int W     = 8,
    parameter int T     = (N + 1) / 2,
    parameter int EARLY = 0,
    localparam int CW   = $clog2(N + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  x,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          y0,
    output logic [CW-1:0] count,
    output logic [1:0]    dbg_state
);

    localparam int C  = (N + W - 1) / W;
    localparam int KW = (C > 1) ? $clog2(C) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(C - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_n;
    logic [N-1:0]    x_q;
    logic [CW-1:0]   acc;
    logic [KW-1:0]   k;
    logic [C*W-1:0]  x_pad;
    logic [W-1:0]    chunk;
    logic [CW-1:0]   chunk_ones;
    logic [CW-1:0]   acc_sum;
    logic            finish;
    int              processed;
    int              remaining;

    assign dbg_state = state;

    // Bits above N-1 in the last chunk read as zero.
    always_comb begin
        x_pad          = '0;
        x_pad[N-1:0]   = x_q;
    end

    always_comb begin
        chunk = '0;
        for (int i = 0; i < C; i++) begin
            if (k == KW'(i)) chunk = x_pad[i*W +: W];
        end
    end

    always_comb begin
        chunk_ones = '0;
        for (int i = 0; i < W; i++) begin
            chunk_ones = chunk_ones + CW'(chunk[i]);
        end
    end

    assign acc_sum = acc + chunk_ones;

    // Early exit once the outcome can no longer change: threshold reached,
    // or even all remaining bits set could not reach it.
    always_comb begin
        processed = (int'(k) + 1) * W;
        if (processed > N) processed = N;
        remaining = N - processed;
        finish    = 1'b0;
        if (k == K_LAST) begin
            finish = 1'b1;
        end else if (EARLY != 0) begin
            if ((int'(acc_sum) >= T) || ((int'(acc_sum) + remaining) < T)) finish = 1'b1;
        end
    end

    always_comb begin
        state_n   = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_n = ACCUM;
            end
            ACCUM: begin
                if (finish) state_n = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q   <= '0;
            acc   <= '0;
            k     <= '0;
            y0    <= 1'b0;
            count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_q <= x;
                        acc <= '0;
                        k   <= '0;
                    end
                end
                ACCUM: begin
                    acc <= acc_sum;
                    k   <= k + KW'(1);
                    if (finish) begin
                        y0    <= (int'(acc_sum) >= T);
                        count <= acc_sum;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
